pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (1..256).
REQ-002 SHALL have parameter SKID, default 1, where 1 = two-entry skid buffer and 0 = single register with combinational ready.
REQ-003 SHALL have parameter CNT_W, default 16, stall counter width.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  upstream payload valid.
REQ-007 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-009 SHALL have port out_valid  output  1  downstream payload valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-011 SHALL have port out_data  output  WIDTH  downstream payload.
REQ-012 SHALL have port flush  input  1  synchronous discard of all held entries (bubble insert).
REQ-013 SHALL have port occupancy  output  2  held entries (0, 1 or 2).
REQ-014 SHALL have port stall_cnt  output  CNT_W  saturating count of back-pressured cycles.
REQ-015 SHALL have port stall_clr  input  1  synchronous clear of stall_cnt.

Function
REQ-016 SHALL define accept = in_valid & in_ready and pop = out_valid & out_ready.
REQ-017 SHALL hold the FSM states EMPTY, ONE and TWO, where TWO is reachable only when SKID=1.
REQ-018 SHALL transition from EMPTY on accept to ONE, loading the main register from in_data.
REQ-019 SHALL, in ONE: on accept & pop stay in ONE and load main; on accept & !pop go to TWO and load skid; on pop only go to EMPTY; otherwise hold.
REQ-020 SHALL, in TWO: on pop go to ONE with main <= skid; otherwise hold.
REQ-021 SHALL drive in_ready = !(state==TWO) directly from flops when SKID=1, with no combinational path from out_ready.
REQ-022 SHALL drive in_ready = (state==EMPTY) | out_ready when SKID=0.
REQ-023 SHALL drive out_valid = (state!=EMPTY) and out_data = main register.
REQ-024 SHALL keep out_data and out_valid stable while out_valid & !out_ready.
REQ-025 SHALL present payload on out_data exactly 1 cycle after acceptance in EMPTY.
REQ-026 SHALL sustain 1 transfer per cycle while out_ready is held high.
REQ-027 SHALL preserve FIFO order; no payload is duplicated or dropped except by flush.
REQ-028 SHALL give flush priority over all events: next state EMPTY, main and skid <= 0, and the same-cycle input discarded.
REQ-029 SHALL hold in_ready per the current state during flush cycles.
REQ-030 SHALL drive occupancy = 0/1/2 for EMPTY/ONE/TWO.
REQ-031 SHALL increment stall_cnt when out_valid & !out_ready, saturating at 2^CNT_W-1 with no wrap.
REQ-032 SHALL clear stall_cnt to 0 on stall_clr, with stall_clr taking priority over a same-cycle increment.
REQ-033 SHALL leave stall_cnt unaffected by flush.

Reset
REQ-034 SHALL, on reset low, asynchronously force state EMPTY, main = 0, skid = 0 and stall_cnt = 0.
REQ-035 SHALL drive these outputs while reset is low: out_valid = 0, out_data = 0, occupancy = 0, in_ready = 1.
REQ-036 SHALL discard any in-flight entries when reset is asserted mid-transfer, with no partial update.
REQ-037 SHALL release reset synchronously at the clk domain boundary, with the first accept possible on the first rising edge after deassertion.

Structure
REQ-038 SHALL take the state encodings ST_EMPTY = 2'd0, ST_ONE = 2'd1 and ST_TWO = 2'd2 from shared package pipe_pkg.
REQ-039 SHALL take the default WIDTH and CNT_W constants from shared package pipe_pkg.
REQ-040 SHALL implement the stall counter in sub-module pipe_sat_counter (parameter CNT_W; inputs inc and clr).
REQ-041 SHALL hold all datapath state in the main and skid registers only.

Verification
REQ-042 SHALL cover: SKID=1, out_ready=1, in_data 0x11, 0x22, 0x33 on consecutive cycles -> out_data 0x11, 0x22, 0x33 on the following three cycles, occupancy 1.
REQ-043 SHALL cover: out_ready=0, send 0xA then 0xB -> occupancy 2, in_ready=0, out_data=0xA held; raise out_ready -> 0xA then 0xB, in_ready=1 one cycle after first pop.
REQ-044 SHALL cover: occupancy 2 and flush=1 with in_valid=1, in_data=0xC -> next cycle out_valid=0, occupancy 0, out_data=0, 0xC never emitted.
REQ-045 SHALL cover: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt saturates at 15; stall_clr with stall active -> 0.
REQ-046 SHALL cover: reset asserted mid-cycle while occupancy 2 -> immediate out_valid=0, in_ready=1, stall_cnt=0, without waiting for clk.
REQ-047 SHALL cover: SKID=0, out_ready=0 with held entry -> in_ready=0; out_ready=1 same cycle -> in_ready=1 and new data accepted back-to-back.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared constants for the pipeline stage register family:
//   - FSM state encodings (EMPTY / ONE / TWO held entries)
//   - default payload and stall-counter widths
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter
// Saturating up-counter with synchronous clear.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset, forces count to 0
//   inc    - count up by one this cycle (ignored once saturated)
//   clr    - synchronous clear, wins over inc
//   count  - current count value
module pipe_sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Valid/ready pipeline stage. With SKID=1 it is a two-entry skid buffer whose
// in_ready comes straight from flops; with SKID=0 it is a single register
// whose in_ready passes out_ready through combinationally.
// Ports:
//   clk, reset           - clock (rising edge), async active-low reset
//   in_valid/in_ready    - upstream handshake, in_data payload
//   out_valid/out_ready  - downstream handshake, out_data payload
//   flush                - synchronous discard of all held entries
//   occupancy            - number of held entries (0..2)
//   stall_cnt/stall_clr  - saturating back-pressure cycle count and its clear
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SKID  = 1,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    input  logic             stall_clr
);

    pipe_state_t      state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             accept;
    logic             pop;
    logic             stall;

    // Skid mode: in_ready depends only on state, so no path from out_ready.
    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = (state != ST_TWO);
        end else begin : g_noskid
            assign in_ready = (state == ST_EMPTY) | out_ready;
        end
    endgenerate

    assign out_valid = (state != ST_EMPTY);
    assign out_data  = main_q;
    assign occupancy = state;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign stall     = out_valid & ~out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            // Flush wins over everything, including a same-cycle accept.
            state  <= ST_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state  <= ST_ONE;
                        main_q <= in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        main_q <= in_data;
                    end else if (accept && (SKID != 0)) begin
                        // Downstream stalled: park the new beat behind main.
                        state  <= ST_TWO;
                        skid_q <= in_data;
                    end else if (pop) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state  <= ST_ONE;
                        main_q <= skid_q;
                    end
                end
                default: begin
                    state <= ST_EMPTY;
                end
            endcase
        end
    end

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall),
        .clr   (stall_clr),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
// Drives a SKID=0 instance (index 0) and a SKID=1 instance (index 1) with
// shared stimulus and compares both against a FIFO-level reference model.
module tb_pipe_stage_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       flush;
    logic       stall_clr;

    logic [1:0] in_ready_w;
    logic [1:0] out_valid_w;
    logic [7:0] od_w  [2];
    logic [1:0] occ_w [2];
    logic [3:0] sc_w  [2];

    int n_chk  = 0;
    int n_fail = 0;

    // reference model: per instance a FIFO of depth 1 or 2
    logic [7:0] ment  [2][2];
    int         mcnt  [2];
    logic [7:0] mlast [2];
    int         msc   [2];

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(8), .SKID(0), .CNT_W(4)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .in_data(in_data), .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .out_data(od_w[0]), .flush(flush), .occupancy(occ_w[0]),
        .stall_cnt(sc_w[0]), .stall_clr(stall_clr)
    );

    pipe_stage_reg #(.WIDTH(8), .SKID(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .in_data(in_data), .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .out_data(od_w[1]), .flush(flush), .occupancy(occ_w[1]),
        .stall_cnt(sc_w[1]), .stall_clr(stall_clr)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mcnt[i]  = 0;
            mlast[i] = 8'h00;
            msc[i]   = 0;
        end
    endtask

    function automatic logic exp_ready(input int i);
        if (i == 1) return (mcnt[i] < 2);
        return (mcnt[i] == 0) || out_ready;
    endfunction

    // Called at a falling edge with inputs applied; checks, advances model
    // by one clock, and returns at the next falling edge.
    task automatic step();
        logic [7:0] od_e;
        logic       acc;
        logic       pop;
        #1;
        for (int i = 0; i < 2; i++) begin
            od_e = (mcnt[i] > 0) ? ment[i][0] : mlast[i];
            chk($sformatf("in_ready%0d", i),  32'(in_ready_w[i]),  32'(exp_ready(i)));
            chk($sformatf("out_valid%0d", i), 32'(out_valid_w[i]), 32'(mcnt[i] > 0));
            chk($sformatf("out_data%0d", i),  32'(od_w[i]),        32'(od_e));
            chk($sformatf("occupancy%0d", i), 32'(occ_w[i]),       32'(mcnt[i]));
            chk($sformatf("stall_cnt%0d", i), 32'(sc_w[i]),        32'(msc[i]));
        end
        for (int i = 0; i < 2; i++) begin
            acc = in_valid && exp_ready(i);
            pop = (mcnt[i] > 0) && out_ready;
            if (stall_clr) msc[i] = 0;
            else if ((mcnt[i] > 0) && !out_ready && (msc[i] < 15)) msc[i]++;
            if (flush) begin
                mcnt[i]  = 0;
                mlast[i] = 8'h00;
            end else begin
                if (pop) begin
                    mlast[i]   = ment[i][0];
                    ment[i][0] = ment[i][1];
                    mcnt[i]--;
                end
                if (acc) begin
                    ment[i][mcnt[i]] = in_data;
                    mcnt[i]++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        out_ready = 1'b0; flush = 1'b0; stall_clr = 1'b0;
        model_reset();

        // reset state
        #12;
        for (int i = 0; i < 2; i++) begin
            chk("rst_out_valid", 32'(out_valid_w[i]), 32'd0);
            chk("rst_in_ready",  32'(in_ready_w[i]),  32'd1);
            chk("rst_out_data",  32'(od_w[i]),        32'd0);
            chk("rst_occ",       32'(occ_w[i]),       32'd0);
            chk("rst_stall",     32'(sc_w[i]),        32'd0);
        end
        @(negedge clk);
        reset = 1'b1;

        // streaming with out_ready high
        out_ready = 1'b1; in_valid = 1'b1;
        in_data = 8'h11; step();
        chk("stream_11", 32'(od_w[1]), 32'h11);
        in_data = 8'h22; step();
        chk("stream_22", 32'(od_w[1]), 32'h22);
        chk("stream_occ", 32'(occ_w[1]), 32'd1);
        in_data = 8'h33; step();
        chk("stream_33", 32'(od_w[1]), 32'h33);
        in_valid = 1'b0; step();

        // back-pressure fills the skid entry
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'h0A; step();
        in_data = 8'h0B; step();
        in_valid = 1'b0;
        chk("bp_occ2",    32'(occ_w[1]),      32'd2);
        chk("bp_ready0",  32'(in_ready_w[1]), 32'd0);
        chk("bp_hold_A",  32'(od_w[1]),       32'h0A);
        step();
        chk("bp_still_A", 32'(od_w[1]),       32'h0A);
        out_ready = 1'b1; step();
        chk("bp_then_B",  32'(od_w[1]),       32'h0B);
        chk("bp_ready1",  32'(in_ready_w[1]), 32'd1);
        step();

        // flush with a simultaneous input
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'h01; step();
        in_data = 8'h02; step();
        flush = 1'b1; in_data = 8'h0C; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", 32'(out_valid_w[1]), 32'd0);
        chk("fl_occ",   32'(occ_w[1]),       32'd0);
        chk("fl_data",  32'(od_w[1]),        32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) step();

        // stall counter saturation and clear
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h44; step();
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) step();
        chk("sat_15", 32'(sc_w[1]), 32'd15);
        chk("sat_15_skid0", 32'(sc_w[0]), 32'd15);
        stall_clr = 1'b1; step();
        stall_clr = 1'b0;
        chk("sat_clr", 32'(sc_w[1]), 32'd0);

        // SKID=0 combinational ready with a held entry
        in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b0;
        #1 chk("ns_ready_lo", 32'(in_ready_w[0]), 32'd0);
        out_ready = 1'b1;
        #1 chk("ns_ready_hi", 32'(in_ready_w[0]), 32'd1);
        step();
        chk("ns_5A", 32'(od_w[0]), 32'h5A);
        in_data = 8'h5B; step();
        chk("ns_5B", 32'(od_w[0]), 32'h5B);
        in_valid = 1'b0; step();

        // asynchronous reset mid-cycle while full
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'h61; step();
        in_data = 8'h62; step();
        chk("ar_pre_occ", 32'(occ_w[1]), 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("ar_valid",  32'(out_valid_w[1]), 32'd0);
        chk("ar_ready",  32'(in_ready_w[1]),  32'd1);
        chk("ar_stall",  32'(sc_w[1]),        32'd0);
        chk("ar_occ",    32'(occ_w[1]),       32'd0);
        chk("ar_data",   32'(od_w[1]),        32'd0);
        model_reset();
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step();

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            stall_clr = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
